// File: rtl/calendar_date_counter_pkg.sv
// -----------------------------------------------------------------------------
// calendar_pkg
// Shared constants for the calendar date counter: month numbers, day-of-week
// codes, calendar sizes, and a small day-of-week increment helper.
// No ports (package). Imported with: import calendar_pkg::*;
// -----------------------------------------------------------------------------
package calendar_pkg;

    // Month numbers as held in the 4-bit month register (1-based).
    localparam logic [3:0] JAN = 4'd1;
    localparam logic [3:0] FEB = 4'd2;
    localparam logic [3:0] MAR = 4'd3;
    localparam logic [3:0] APR = 4'd4;
    localparam logic [3:0] MAY = 4'd5;
    localparam logic [3:0] JUN = 4'd6;
    localparam logic [3:0] JUL = 4'd7;
    localparam logic [3:0] AUG = 4'd8;
    localparam logic [3:0] SEP = 4'd9;
    localparam logic [3:0] OCT = 4'd10;
    localparam logic [3:0] NOV = 4'd11;
    localparam logic [3:0] DEC = 4'd12;

    // Day-of-week codes, 0 = Sunday.
    localparam logic [2:0] DOW_SUN = 3'd0;
    localparam logic [2:0] DOW_MON = 3'd1;
    localparam logic [2:0] DOW_TUE = 3'd2;
    localparam logic [2:0] DOW_WED = 3'd3;
    localparam logic [2:0] DOW_THU = 3'd4;
    localparam logic [2:0] DOW_FRI = 3'd5;
    localparam logic [2:0] DOW_SAT = 3'd6;

    localparam int MONTHS_PER_YEAR = 12;
    localparam int DAYS_PER_WEEK   = 7;

    // Next day of the week, wrapping Saturday back to Sunday.
    function automatic logic [2:0] next_dow(input logic [2:0] cur);
        return (cur == DOW_SAT) ? DOW_SUN : cur + 3'd1;
    endfunction

endpackage

// File: rtl/calendar_date_counter_if.sv
// -----------------------------------------------------------------------------
// calendar_date_counter_if
// Groups the tick/load request signals and the registered date outputs.
//   master: drives day_tick, load_en, load_day/month/year/dow;
//           observes day, month, year, dow, month_wrap, year_wrap, load_err.
//   slave : the calendar core (opposite directions).
// Handshake: day_tick and load_en are single-cycle strobes with no ready;
// the core accepts every strobe and shows the result one cycle later.
// -----------------------------------------------------------------------------
interface calendar_date_counter_if #(
    parameter int YEAR_W = 7
);
    logic              day_tick;
    logic              load_en;
    logic [4:0]        load_day;
    logic [3:0]        load_month;
    logic [YEAR_W-1:0] load_year;
    logic [2:0]        load_dow;

    logic [4:0]        day;
    logic [3:0]        month;
    logic [YEAR_W-1:0] year;
    logic [2:0]        dow;
    logic              month_wrap;
    logic              year_wrap;
    logic              load_err;

    modport master (
        output day_tick, load_en, load_day, load_month, load_year, load_dow,
        input  day, month, year, dow, month_wrap, year_wrap, load_err
    );

    modport slave (
        input  day_tick, load_en, load_day, load_month, load_year, load_dow,
        output day, month, year, dow, month_wrap, year_wrap, load_err
    );
endinterface

// File: rtl/calendar_date_counter_days_in_month_lut.sv
// -----------------------------------------------------------------------------
// days_in_month_lut
// Combinational month-length table.
//   i_month [3:0] : month number 1..12
//   i_leap        : 1 when the year is a leap year
//   o_days  [4:0] : number of days in that month (months outside 1..12 give 31)
// -----------------------------------------------------------------------------
module days_in_month_lut
    import calendar_pkg::*;
(
    input  logic [3:0] i_month,
    input  logic       i_leap,
    output logic [4:0] o_days
);

    always_comb begin
        o_days = 5'd31;
        case (i_month)
            FEB:                o_days = i_leap ? 5'd29 : 5'd28;
            APR, JUN, SEP, NOV: o_days = 5'd30;
            default:            o_days = 5'd31;
        endcase
    end

endmodule

// File: rtl/calendar_date_counter.sv
// -----------------------------------------------------------------------------
// calendar_date_counter
// Holds day, month, year offset and day-of-week; advances one day per
// day_tick and accepts validated loads. All outputs are registered.
//   clk    : system clock
//   rst    : synchronous active-high reset
//   io_cal : calendar_date_counter_if.slave
//            in : day_tick, load_en, load_day, load_month, load_year, load_dow
//            out: day, month, year, dow, month_wrap, year_wrap, load_err
// Optional feature macro: CALENDAR_LEAP_YEAR_EN
//   defined   -> February has 29 days when the year is divisible by 4
//   undefined -> February always has 28 days
// -----------------------------------------------------------------------------
module calendar_date_counter
    import calendar_pkg::*;
#(
    parameter int YEAR_W    = 7,
    parameter int YEAR_MAX  = 99,
    parameter int BASE_YEAR = 2000,
    parameter int RESET_DOW = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    calendar_date_counter_if.slave  io_cal
);

    logic [4:0]        r_day;
    logic [3:0]        r_month;
    logic [YEAR_W-1:0] r_year;
    logic [2:0]        r_dow;
    logic              r_month_wrap;
    logic              r_year_wrap;
    logic              r_load_err;

    logic [1:0]        w_cur_year_lsbs;
    logic [1:0]        w_load_year_lsbs;
    logic              w_cur_leap;
    logic              w_load_leap;
    logic [4:0]        w_cur_dim;
    logic [4:0]        w_load_dim;
    logic              w_load_valid;
    logic [YEAR_W-1:0] w_year_next;

    // Leap parity is taken on the absolute year; with a base year that is a
    // multiple of 400 and a window under a century this is just offset % 4.
    assign w_cur_year_lsbs  = r_year[1:0] + 2'(BASE_YEAR);
    assign w_load_year_lsbs = io_cal.load_year[1:0] + 2'(BASE_YEAR);

`ifdef CALENDAR_LEAP_YEAR_EN
    assign w_cur_leap  = (w_cur_year_lsbs == 2'b00);
    assign w_load_leap = (w_load_year_lsbs == 2'b00);
`else
    // Leap years disabled: the year parity never matters.
    assign w_cur_leap  = 1'b0 & (w_cur_year_lsbs == 2'b00);
    assign w_load_leap = 1'b0 & (w_load_year_lsbs == 2'b00);
`endif

    days_in_month_lut u_dim_cur (
        .i_month (r_month),
        .i_leap  (w_cur_leap),
        .o_days  (w_cur_dim)
    );

    days_in_month_lut u_dim_load (
        .i_month (io_cal.load_month),
        .i_leap  (w_load_leap),
        .o_days  (w_load_dim)
    );

    assign w_load_valid = (io_cal.load_month >= JAN)
                        && (io_cal.load_month <= 4'(MONTHS_PER_YEAR))
                        && (io_cal.load_day   >= 5'd1)
                        && (io_cal.load_day   <= w_load_dim)
                        && (io_cal.load_year  <= YEAR_W'(YEAR_MAX))
                        && (io_cal.load_dow   <  3'(DAYS_PER_WEEK));

    // >= rather than == keeps the year inside the window even if it were
    // ever out of range; loads cannot put it there.
    assign w_year_next = (r_year >= YEAR_W'(YEAR_MAX)) ? '0 : r_year + YEAR_W'(1);

    always_ff @(posedge clk) begin
        // Pulses default low; the branches below raise them for one cycle.
        r_month_wrap <= 1'b0;
        r_year_wrap  <= 1'b0;
        r_load_err   <= 1'b0;
        if (rst) begin
            r_day   <= 5'd1;
            r_month <= JAN;
            r_year  <= '0;
            r_dow   <= 3'(RESET_DOW);
        end else if (io_cal.load_en) begin
            // A load request always consumes the cycle, even when rejected,
            // so a coincident tick is dropped.
            if (w_load_valid) begin
                r_day   <= io_cal.load_day;
                r_month <= io_cal.load_month;
                r_year  <= io_cal.load_year;
                r_dow   <= io_cal.load_dow;
            end else begin
                r_load_err <= 1'b1;
            end
        end else if (io_cal.day_tick) begin
            r_dow <= next_dow(r_dow);
            if (r_day < w_cur_dim) begin
                r_day <= r_day + 5'd1;
            end else begin
                r_day        <= 5'd1;
                r_month_wrap <= 1'b1;
                if (r_month >= DEC) begin
                    r_month     <= JAN;
                    r_year      <= w_year_next;
                    r_year_wrap <= 1'b1;
                end else begin
                    r_month <= r_month + 4'd1;
                end
            end
        end
    end

    assign io_cal.day        = r_day;
    assign io_cal.month      = r_month;
    assign io_cal.year       = r_year;
    assign io_cal.dow        = r_dow;
    assign io_cal.month_wrap = r_month_wrap;
    assign io_cal.year_wrap  = r_year_wrap;
    assign io_cal.load_err   = r_load_err;

endmodule

// File: tb/tb_calendar_date_counter.sv
// -----------------------------------------------------------------------------
// tb_calendar_date_counter
// Self-checking bench: a date model driven from the calendar rules, an
// expected queue filled on each clock edge and drained by one compare process,
// plus literal expectations for the directed scenarios.
// -----------------------------------------------------------------------------
module tb_calendar_date_counter;

  localparam int YEAR_W = 7;
  localparam int EXP_W  = 5 + 4 + YEAR_W + 3 + 3;

  logic clk;
  logic rst;

  calendar_date_counter_if #(.YEAR_W(YEAR_W)) cal_if ();

  calendar_date_counter #(
    .YEAR_W    (YEAR_W),
    .YEAR_MAX  (99),
    .BASE_YEAR (2000),
    .RESET_DOW (6)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_cal (cal_if)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  logic [EXP_W-1:0] exp_q[$];
  int m_day = 1, m_month = 1, m_year = 0, m_dow = 6;

  function automatic bit is_leap(input int y);
`ifdef CALENDAR_LEAP_YEAR_EN
    return ((2000 + y) % 4) == 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int days_in(input int m, input int y);
    int tbl[12];
    tbl = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m < 1 || m > 12) return 31;
    if (m == 2 && is_leap(y)) return 29;
    return tbl[m-1];
  endfunction

  function automatic bit load_ok(input int d, input int m, input int y, input int w);
    if (m < 1 || m > 12) return 1'b0;
    if (d < 1 || d > days_in(m, y)) return 1'b0;
    if (y > 99) return 1'b0;
    if (w > 6) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [EXP_W-1:0] pack(input int d, input int m, input int y,
                                            input int w, input bit mw, input bit yw,
                                            input bit le);
    return {5'(d), 4'(m), YEAR_W'(y), 3'(w), mw, yw, le};
  endfunction

  always @(posedge clk) begin
    bit mw, yw, le;
    int ld, lm, ly, lw;
    mw = 0; yw = 0; le = 0;
    ld = int'(cal_if.load_day);
    lm = int'(cal_if.load_month);
    ly = int'(cal_if.load_year);
    lw = int'(cal_if.load_dow);
    if (rst === 1'b1) begin
      m_day = 1; m_month = 1; m_year = 0; m_dow = 6;
    end else if (cal_if.load_en === 1'b1) begin
      if (load_ok(ld, lm, ly, lw)) begin
        m_day = ld; m_month = lm; m_year = ly; m_dow = lw;
      end else begin
        le = 1;
      end
    end else if (cal_if.day_tick === 1'b1) begin
      m_dow = (m_dow + 1) % 7;
      m_day = m_day + 1;
      if (m_day > days_in(m_month, m_year)) begin
        m_day = 1;
        m_month = m_month + 1;
        mw = 1;
        if (m_month > 12) begin
          m_month = 1;
          m_year = (m_year + 1) % 100;
          yw = 1;
        end
      end
    end
    exp_q.push_back(pack(m_day, m_month, m_year, m_dow, mw, yw, le));
  end

  function automatic logic [EXP_W-1:0] dut_vec();
    return {cal_if.day, cal_if.month, cal_if.year, cal_if.dow,
            cal_if.month_wrap, cal_if.year_wrap, cal_if.load_err};
  endfunction

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = dut_vec();
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL model_cmp t=%0t got d=%0d m=%0d y=%0d w=%0d mw=%0b yw=%0b le=%0b exp d=%0d m=%0d y=%0d w=%0d mw=%0b yw=%0b le=%0b",
                 $time, a[EXP_W-1 -: 5], a[EXP_W-6 -: 4], a[YEAR_W+5 -: YEAR_W], a[5:3], a[2], a[1], a[0],
                 e[EXP_W-1 -: 5], e[EXP_W-6 -: 4], e[YEAR_W+5 -: YEAR_W], e[5:3], e[2], e[1], e[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit r, input bit t, input bit l,
                     input int d, input int m, input int y, input int w);
    rst = r;
    cal_if.day_tick   = t;
    cal_if.load_en    = l;
    cal_if.load_day   = 5'(d);
    cal_if.load_month = 4'(m);
    cal_if.load_year  = YEAR_W'(y);
    cal_if.load_dow   = 3'(w);
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    cyc(0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic load(input int d, input int m, input int y, input int w);
    cyc(0, 0, 1, d, m, y, w);
  endtask

  task automatic check_lit(input string name, input int d, input int m, input int y,
                           input int w, input bit mw, input bit yw, input bit le);
    logic [EXP_W-1:0] e, a;
    e = pack(d, m, y, w, mw, yw, le);
    a = dut_vec();
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL %s got d=%0d m=%0d y=%0d w=%0d mw=%0b yw=%0b le=%0b exp d=%0d m=%0d y=%0d w=%0d mw=%0b yw=%0b le=%0b",
               name, cal_if.day, cal_if.month, cal_if.year, cal_if.dow,
               cal_if.month_wrap, cal_if.year_wrap, cal_if.load_err, d, m, y, w, mw, yw, le);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d, m, y, w;
    bit r, t, l;
    rst = 1'b1;
    cal_if.day_tick = 1'b0;
    cal_if.load_en = 1'b0;
    cal_if.load_day = '0;
    cal_if.load_month = '0;
    cal_if.load_year = '0;
    cal_if.load_dow = '0;

    // Reset for two cycles, then release.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check_lit("reset", 1, 1, 0, 6, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check_lit("idle_after_reset", 1, 1, 0, 6, 0, 0, 0);

    // Month rollover.
    load(30, 4, 5, 3);
    check_lit("load_30_04_05", 30, 4, 5, 3, 0, 0, 0);
    tick();
    check_lit("month_roll", 1, 5, 5, 4, 1, 0, 0);
    tick();
    check_lit("pulse_clears", 2, 5, 5, 5, 0, 0, 0);

    // Year and window wrap.
    load(31, 12, 99, 5);
    check_lit("load_31_12_99", 31, 12, 99, 5, 0, 0, 0);
    tick();
    check_lit("year_wrap", 1, 1, 0, 6, 1, 1, 0);

    // Leap handling.
    load(28, 2, 24, 0);
    tick();
`ifdef CALENDAR_LEAP_YEAR_EN
    check_lit("leap_feb29", 29, 2, 24, 1, 0, 0, 0);
    tick();
    check_lit("leap_mar1", 1, 3, 24, 2, 1, 0, 0);
    load(29, 2, 23, 4);
    check_lit("nonleap_feb29_rej", 1, 3, 24, 2, 0, 0, 1);
`else
    check_lit("noleap_mar1", 1, 3, 24, 1, 1, 0, 0);
    load(29, 2, 24, 4);
    check_lit("feb29_rej", 1, 3, 24, 1, 0, 0, 1);
`endif

    // Invalid loads against a known state.
    load(10, 10, 10, 4);
    check_lit("load_10_10_10", 10, 10, 10, 4, 0, 0, 0);
    load(31, 6, 10, 2);
    check_lit("rej_31_jun", 10, 10, 10, 4, 0, 0, 1);
    load(0, 1, 0, 0);
    check_lit("rej_day0", 10, 10, 10, 4, 0, 0, 1);
    load(1, 13, 0, 0);
    check_lit("rej_month13", 10, 10, 10, 4, 0, 0, 1);
    load(1, 1, 100, 0);
    check_lit("rej_year100", 10, 10, 10, 4, 0, 0, 1);
    load(1, 1, 0, 7);
    check_lit("rej_dow7", 10, 10, 10, 4, 0, 0, 1);

    // Load and tick together: load wins.
    cyc(0, 1, 1, 15, 7, 30, 2);
    check_lit("load_beats_tick", 15, 7, 30, 2, 0, 0, 0);
    // Invalid load and tick together: tick still dropped.
    cyc(0, 1, 1, 31, 9, 30, 2);
    check_lit("badload_beats_tick", 15, 7, 30, 2, 0, 0, 1);

    // Reset mid-run during a stream of ticks.
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 40; i++) begin
      cyc((i == 20), 1, 0, 0, 0, 0, 0);
      if (i == 19) check_lit("ticks_19", 20, 1, 0, 4, 0, 0, 0);
      if (i == 20) check_lit("mid_reset", 1, 1, 0, 6, 0, 0, 0);
    end
    check_lit("after_20_ticks", 21, 1, 0, 5, 0, 0, 0);

    // Randomized traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 499) == 0);
      t = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 1) begin
        d = ($urandom_range(0, 1) == 1) ? $urandom_range(26, 31) : $urandom_range(1, 31);
        m = $urandom_range(1, 12);
        y = ($urandom_range(0, 3) == 0) ? 99 : $urandom_range(0, 99);
        w = $urandom_range(0, 6);
      end else begin
        d = $urandom_range(0, 31);
        m = $urandom_range(0, 15);
        y = $urandom_range(0, 127);
        w = $urandom_range(0, 7);
      end
      cyc(r, t, l, d, m, y, w);
    end

    cyc(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
